xor_seq_detector: RTL and testbench

Parametrised serial sequence detector, the generalised successor to the two-input XOR shift-register detector.
- The XOR-reduction of N_CH input bits forms one serial bit W per sampled clock.
- W is shifted into a PAT_LEN-bit history register and compared against a runtime-loadable pattern.
- The block raises a one-cycle match pulse and keeps a saturating match count.
- Intended as the reusable detector for chapter-6 FSM exercises and later framing/sync logic.

---
 rtl/xor_seq_detector.sv | 100 ++++++++++
 tb/tb_xor_seq_detector.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/xor_seq_detector.sv
// rtl/xor_seq_detector.sv - XOR-reduced serial sequence detector with saturating match count.
// Define XOR_SEQ_STICKY_EN to add the clr_seen input and the sticky seen output.
module xor_seq_detector #(
  parameter int                 N_CH    = 2,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [N_CH-1:0]                w,
  input  logic                           pat_load,
  input  logic [PAT_LEN-1:0]             pat_in,
`ifdef XOR_SEQ_STICKY_EN
  input  logic                           clr_seen,
  output logic                           seen,
`endif
  output logic                           z,
  output logic [CNT_W-1:0]               match_cnt,
  output logic [$clog2(PAT_LEN+1)-1:0]   fill
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] hist_q, hist_d, hist_n;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_n;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               z_q, z_d;
  logic               hit;

  always_comb begin
    hist_n = {hist_q[PAT_LEN-2:0], ^w};
    fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    // fill guard keeps an all-zero pattern from matching the cleared history
    hit    = en && !pat_load && (fill_n == FILL_FULL) && (hist_n == pat_q);

    hist_d = hist_q;
    pat_d  = pat_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    z_d    = 1'b0;

    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_n;
      fill_d = fill_n;
      z_d    = hit;
      if (hit) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (OVERLAP == 0) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      pat_q  <= PATTERN;
      fill_q <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
    end
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

`ifdef XOR_SEQ_STICKY_EN
  logic seen_q, seen_d;

  always_comb begin
    seen_d = seen_q;
    if (hit) seen_d = 1'b1;
    else if (clr_seen) seen_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) seen_q <= 1'b0;
    else     seen_q <= seen_d;
  end

  assign seen = seen_q;
`endif

endmodule

// File: tb/tb_xor_seq_detector.sv
// tb/tb_xor_seq_detector.sv - scoreboard bench for xor_seq_detector across three configurations.
module tb_xor_seq_detector;
  localparam int PL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       pat_load = 1'b0;
  logic [1:0] w = 2'b00;
  logic [3:0] pat_in = 4'b0000;

  logic       z_a, z_b, z_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [2:0] fill_a, fill_b, fill_c;

  always #5 clk = ~clk;

  xor_seq_detector #(.OVERLAP(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .w(w), .pat_load(pat_load), .pat_in(pat_in),
    .z(z_a), .match_cnt(cnt_a), .fill(fill_a));
  xor_seq_detector #(.OVERLAP(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .w(w), .pat_load(pat_load), .pat_in(pat_in),
    .z(z_b), .match_cnt(cnt_b), .fill(fill_b));
  xor_seq_detector #(.OVERLAP(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .en(en), .w(w), .pat_load(pat_load), .pat_in(pat_in),
    .z(z_c), .match_cnt(cnt_c), .fill(fill_c));

  typedef struct packed {
    logic [2:0]      z;
    logic [2:0][7:0] c;
    logic [2:0][2:0] f;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: all accepted samples since the last reset/load, plus a per-instance
  // start index marking where that instance's current window begins.
  bit       samples[$];
  int       start[3];
  int       cnt[3];
  bit       zm[3];
  logic [3:0] pat;
  int       ovl[3]  = '{1, 0, 1};
  int       cmax[3] = '{255, 255, 3};

  function automatic bit tail_matches();
    int n = samples.size();
    if (n < PL) return 1'b0;
    for (int k = 0; k < PL; k++)
      if (samples[n-1-k] != pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model(input bit r, input bit e, input bit pl, input logic [3:0] pi, input bit b);
    exp_t x;
    int   n;
    bit   tm;
    if (r) begin
      samples.delete();
      pat = 4'b1001;
      for (int i = 0; i < 3; i++) begin start[i] = 0; cnt[i] = 0; zm[i] = 1'b0; end
    end else if (pl) begin
      samples.delete();
      pat = pi;
      for (int i = 0; i < 3; i++) begin start[i] = 0; zm[i] = 1'b0; end
    end else if (e) begin
      samples.push_back(b);
      tm = tail_matches();
      for (int i = 0; i < 3; i++) begin
        n = samples.size() - start[i];
        zm[i] = tm && (n >= PL);
        if (zm[i]) begin
          if (cnt[i] < cmax[i]) cnt[i]++;
          if (ovl[i] == 0) start[i] = samples.size();
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) zm[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      n = samples.size() - start[i];
      x.z[i] = zm[i];
      x.c[i] = 8'(cnt[i]);
      x.f[i] = 3'((n > PL) ? PL : n);
    end
    sb.push_back(x);
  endtask

  task automatic step(input bit r, input bit e, input bit pl, input logic [3:0] pi, input bit b);
    rst      = r;
    en       = e;
    pat_load = pl;
    pat_in   = pi;
    w[1]     = 1'($urandom_range(0, 1));
    w[0]     = w[1] ^ b;
    @(posedge clk);
    model(r, e, pl, pi, b);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("z_a", int'(z_a), int'(x.z[0]));
        chk("z_b", int'(z_b), int'(x.z[1]));
        chk("z_c", int'(z_c), int'(x.z[2]));
        chk("cnt_a", int'(cnt_a), int'(x.c[0]));
        chk("cnt_b", int'(cnt_b), int'(x.c[1]));
        chk("cnt_c", int'(cnt_c), int'(x.c[2]));
        chk("fill_a", int'(fill_a), int'(x.f[0]));
        chk("fill_b", int'(fill_b), int'(x.f[1]));
        chk("fill_c", int'(fill_c), int'(x.f[2]));
      end
    end
  end

  task automatic stream(input logic [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) step(1'b0, 1'b1, 1'b0, 4'b0000, bits[i]);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
    stream(16'b1001001, 7);

    step(1'b0, 1'b1, 1'b1, 4'b0000, 1'b1);
    stream(16'b00000, 5);

    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    stream(16'b10, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'b0000, i[0]);
    stream(16'b01, 2);

    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    stream(16'b1111111, 7);

    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    stream(16'b100, 3);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    stream(16'b1001, 4);

    for (int i = 0; i < 600; i++) begin
      bit r, e, pl, b;
      logic [3:0] pi;
      r  = ($urandom_range(0, 99) < 1);
      pl = ($urandom_range(0, 99) < 3);
      e  = ($urandom_range(0, 99) < 80);
      b  = 1'($urandom_range(0, 1));
      pi = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      step(r, e, pl, pi, b);
    end

    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
